// File: rtl/stepper_phase_monitor.sv
// rtl/stepper_phase_monitor.sv - position/health monitor for a one-hot stepper coil drive bus
// Optional macro POS_SAT_EN: saturating position counter with sat flag (default wraps, sat=0).
module stepper_phase_monitor #(
   parameter int POS_W = 8
) (
   input  logic                    drv_clk,
   input  logic                    reset,
   input  logic [3:0]              motor_drv,
   input  logic                    clr_fault,
   input  logic                    pos_zero,
   output logic signed [POS_W-1:0] pos,
   output logic                    step_fwd,
   output logic                    step_rev,
   output logic                    idle,
   output logic                    at_home,
   output logic                    fault,
   output logic [1:0]              fault_code,
   output logic                    sat
);

   typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;
   typedef enum logic [2:0] {C_SAME, C_FWD, C_REV, C_SKIP, C_IDLE, C_ILLEGAL} cls_t;

   localparam logic signed [POS_W-1:0] ONE = POS_W'(1);
`ifdef POS_SAT_EN
   localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
   logic sat_q;
   logic sat_nxt;
   assign sat = sat_q;
`else
   assign sat = 1'b0;
`endif

   state_t                  state;
   cls_t                    cls;
   logic [3:0]              sample;
   logic [1:0]              ref_ph;
   logic [1:0]              idx;
   logic [1:0]              diff;
   logic                    one_hot;
   logic signed [POS_W-1:0] pos_nxt;

   // Phase index of the registered sample and its class relative to the reference phase.
   always_comb begin
      idx     = 2'd0;
      one_hot = 1'b1;
      case (sample)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: one_hot = 1'b0;
      endcase
      diff = idx - ref_ph;
      if (sample == 4'b0000)
         cls = C_IDLE;
      else if (!one_hot)
         cls = C_ILLEGAL;
      else begin
         case (diff)
            2'd0:    cls = C_SAME;
            2'd1:    cls = C_FWD;
            2'd2:    cls = C_SKIP;
            default: cls = C_REV;
         endcase
      end
   end

   // Position after a step; only consumed for FWD/REV in TRACK.
   always_comb begin
      pos_nxt = pos;
`ifdef POS_SAT_EN
      sat_nxt = sat_q;
      if (cls == C_FWD) begin
         sat_nxt = (pos == POS_MAX);
         if (pos != POS_MAX) pos_nxt = pos + ONE;
      end else if (cls == C_REV) begin
         sat_nxt = (pos == POS_MIN);
         if (pos != POS_MIN) pos_nxt = pos - ONE;
      end
`else
      if (cls == C_FWD)
         pos_nxt = pos + ONE;
      else if (cls == C_REV)
         pos_nxt = pos - ONE;
`endif
   end

   always_ff @(posedge drv_clk or posedge reset) begin
      if (reset) begin
         state      <= SYNC;
         sample     <= 4'b0000;
         ref_ph     <= 2'd0;
         pos        <= '0;
         step_fwd   <= 1'b0;
         step_rev   <= 1'b0;
         idle       <= 1'b0;
         at_home    <= 1'b0;
         fault      <= 1'b0;
         fault_code <= 2'b00;
`ifdef POS_SAT_EN
         sat_q      <= 1'b0;
`endif
      end else begin
         sample   <= motor_drv;
         step_fwd <= 1'b0;
         step_rev <= 1'b0;
         idle     <= 1'b0;
         case (state)
            SYNC: begin
               case (cls)
                  C_IDLE: idle <= 1'b1;
                  C_ILLEGAL: begin
                     state      <= FAULT;
                     fault      <= 1'b1;
                     fault_code <= 2'b01;
                  end
                  default: begin
                     state   <= TRACK;
                     ref_ph  <= idx;
                     at_home <= (idx == 2'd0);
                  end
               endcase
            end
            TRACK: begin
               case (cls)
                  C_IDLE: idle <= 1'b1;
                  C_FWD, C_REV: begin
                     step_fwd <= (cls == C_FWD);
                     step_rev <= (cls == C_REV);
                     ref_ph   <= idx;
                     at_home  <= (idx == 2'd0);
                     pos      <= pos_nxt;
`ifdef POS_SAT_EN
                     sat_q    <= sat_nxt;
`endif
                  end
                  C_SKIP, C_ILLEGAL: begin
                     state      <= FAULT;
                     fault      <= 1'b1;
                     fault_code <= (cls == C_SKIP) ? 2'b10 : 2'b01;
                     at_home    <= 1'b0;
                  end
                  default: ;
               endcase
            end
            FAULT: begin
               if (clr_fault) begin
                  state      <= SYNC;
                  fault      <= 1'b0;
                  fault_code <= 2'b00;
               end
            end
            default: state <= SYNC;
         endcase
         // Position clear beats any step decided on this same edge.
         if (pos_zero) begin
            pos <= '0;
`ifdef POS_SAT_EN
            sat_q <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_stepper_phase_monitor.sv
// tb/tb_stepper_phase_monitor.sv - directed self-checking bench for stepper_phase_monitor
module tb_stepper_phase_monitor;

   logic              drv_clk = 1'b0;
   logic              reset = 1'b1;
   logic [3:0]        motor_drv = 4'b0000;
   logic              clr_fault = 1'b0;
   logic              pos_zero = 1'b0;
   logic signed [3:0] pos;
   logic              step_fwd, step_rev, idle, at_home, fault, sat;
   logic [1:0]        fault_code;

   int total = 0;
   int bad = 0;

   stepper_phase_monitor #(.POS_W(4)) dut (
      .drv_clk(drv_clk), .reset(reset), .motor_drv(motor_drv),
      .clr_fault(clr_fault), .pos_zero(pos_zero), .pos(pos),
      .step_fwd(step_fwd), .step_rev(step_rev), .idle(idle),
      .at_home(at_home), .fault(fault), .fault_code(fault_code), .sat(sat)
   );

   always #5 drv_clk = ~drv_clk;

   task automatic check(input string tag, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Drive one sample, then look 1 time unit after the edge; outputs reflect the previous sample.
   task automatic cyc(input logic [3:0] d);
      motor_drv = d;
      @(posedge drv_clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      motor_drv = 4'b0000;
      clr_fault = 1'b0;
      pos_zero = 1'b0;
      @(posedge drv_clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // reset state
      @(posedge drv_clk);
      #1;
      check("rst_pos", pos, 0);
      check("rst_fwd", step_fwd, 0);
      check("rst_rev", step_rev, 0);
      check("rst_idle", idle, 0);
      check("rst_home", at_home, 0);
      check("rst_fault", fault, 0);
      check("rst_code", fault_code, 0);
      check("rst_sat", sat, 0);
      reset = 1'b0;

      // forward rotation
      cyc(4'b0001);
      cyc(4'b0010);
      check("f_sync_step", step_fwd, 0);
      check("f_sync_pos", pos, 0);
      check("f_sync_home", at_home, 1);
      cyc(4'b0100);
      check("f1_step", step_fwd, 1);
      check("f1_pos", pos, 1);
      check("f1_home", at_home, 0);
      cyc(4'b1000);
      check("f2_pos", pos, 2);
      cyc(4'b0001);
      check("f3_pos", pos, 3);
      cyc(4'b0001);
      check("f4_step", step_fwd, 1);
      check("f4_pos", pos, 4);
      check("f4_home", at_home, 1);
      cyc(4'b0001);
      check("f_same_step", step_fwd, 0);

      // reverse rotation
      do_reset();
      cyc(4'b0100);
      cyc(4'b0010);
      check("r_sync_rev", step_rev, 0);
      cyc(4'b0001);
      check("r1_rev", step_rev, 1);
      check("r1_pos", pos, -1);
      cyc(4'b1000);
      check("r2_pos", pos, -2);
      cyc(4'b1000);
      check("r3_rev", step_rev, 1);
      check("r3_pos", pos, -3);
      check("r3_fwd", step_fwd, 0);
      cyc(4'b1000);
      check("r_same_rev", step_rev, 0);
      check("r_fault", fault, 0);

      // idle gap keeps the reference phase
      do_reset();
      cyc(4'b0001);
      cyc(4'b0000);
      for (int i = 0; i < 4; i++) begin
         cyc(4'b0000);
         check("gap_idle", idle, 1);
         check("gap_step", step_fwd, 0);
      end
      cyc(4'b0010);
      check("gap_idle5", idle, 1);
      cyc(4'b0010);
      check("gap_step_after", step_fwd, 1);
      check("gap_pos_after", pos, 1);
      check("gap_idle_after", idle, 0);

      // phase skip, ignore while faulted, clear and resync
      do_reset();
      cyc(4'b0001);
      cyc(4'b0010);
      cyc(4'b1000);
      check("sk_pos1", pos, 1);
      cyc(4'b0001);
      check("sk_fault", fault, 1);
      check("sk_code", fault_code, 2);
      check("sk_pos", pos, 1);
      cyc(4'b0010);
      cyc(4'b0100);
      check("sk_ign_fault", fault, 1);
      check("sk_ign_pos", pos, 1);
      check("sk_ign_step", step_fwd, 0);
      clr_fault = 1'b1;
      cyc(4'b1000);
      clr_fault = 1'b0;
      check("clr_fault", fault, 0);
      check("clr_code", fault_code, 0);
      cyc(4'b1000);
      check("resync_step", step_fwd, 0);
      check("resync_pos", pos, 1);
      cyc(4'b0001);
      cyc(4'b0001);
      check("resync_fwd", step_fwd, 1);
      check("resync_pos2", pos, 2);

      // illegal pattern, then asynchronous reset mid-cycle
      do_reset();
      cyc(4'b0011);
      cyc(4'b0011);
      check("ill_fault", fault, 1);
      check("ill_code", fault_code, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_fault", fault, 0);
      check("async_code", fault_code, 0);
      @(posedge drv_clk);
      #1;
      reset = 1'b0;

      // eight forward steps at POS_W=4
      cyc(4'b0001);
      cyc(4'b0010);
      for (int i = 2; i <= 9; i++) begin
         cyc(4'(1 << (i % 4)));
         check("w_step", step_fwd, 1);
         if (i <= 8)
            check("w_pos", pos, i - 1);
         else begin
`ifdef POS_SAT_EN
            check("w_pos_last", pos, 7);
            check("w_sat", sat, 1);
`else
            check("w_pos_last", pos, -8);
            check("w_sat", sat, 0);
`endif
         end
      end
      pos_zero = 1'b1;
      cyc(4'b0100);
      pos_zero = 1'b0;
      check("pz_pos", pos, 0);
      check("pz_step", step_fwd, 1);
      check("pz_sat", sat, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
